// File: rtl/borrow_bypass_subtractor.sv
// Multi-cycle WIDTH-bit subtractor (a - b - bin), one BLOCK-bit borrow-bypass slice per clock,
// with valid/ready handshakes on both the operand and the result side.
module borrow_bypass_subtractor #(
  parameter int WIDTH = 8,
  parameter int BLOCK = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH-1:0]                   a,
  input  logic [WIDTH-1:0]                   b,
  input  logic                               bin,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WIDTH-1:0]                   diff,
  output logic                               bout,
  output logic                               ovf,
  output logic [$clog2(WIDTH/BLOCK+1)-1:0]   skip_cnt
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int KW   = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int SW   = $clog2(NBLK + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] opa_p0, opb_p0;
  logic             borrow_p0;
  logic [KW-1:0]    k_p0;

  logic [WIDTH-1:0] diff_p1;
  logic             bout_p1, ovf_p1;
  logic [SW-1:0]    skip_p1;

  logic [BLOCK-1:0] sa, sb, s_diff;
  logic             s_bout, s_skip;
  logic [WIDTH-1:0] diff_upd;
  logic             accept, last;

  // Returns {skip, borrow_out, diff} for one slice; a fully propagating slice
  // forwards its borrow-in instead of waiting on the ripple.
  function automatic logic [BLOCK+1:0] slice_sub(input logic [BLOCK-1:0] xa,
                                                 input logic [BLOCK-1:0] xb,
                                                 input logic             br_in);
    logic [BLOCK-1:0] p, d;
    logic             br, g;
    br = br_in;
    p  = '0;
    d  = '0;
    for (int i = 0; i < BLOCK; i++) begin
      p[i] = ~(xa[i] ^ xb[i]);
      g    = ~xa[i] & xb[i];
      d[i] = xa[i] ^ xb[i] ^ br;
      br   = g | (p[i] & br);
    end
    return {&p, (&p) ? br_in : br, d};
  endfunction

  assign accept = in_valid && in_ready;
  assign last   = (k_p0 == KW'(NBLK - 1));

  always_comb begin
    sa = '0;
    sb = '0;
    for (int j = 0; j < NBLK; j++) begin
      if (k_p0 == KW'(j)) begin
        sa = opa_p0[j*BLOCK +: BLOCK];
        sb = opb_p0[j*BLOCK +: BLOCK];
      end
    end
  end

  assign {s_skip, s_bout, s_diff} = slice_sub(sa, sb, borrow_p0);

  always_comb begin
    diff_upd = diff_p1;
    for (int j = 0; j < NBLK; j++) begin
      if (k_p0 == KW'(j)) diff_upd[j*BLOCK +: BLOCK] = s_diff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  // Stage 0: operand latch and per-slice borrow chain state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_p0    <= '0;
      opb_p0    <= '0;
      borrow_p0 <= 1'b0;
      k_p0      <= '0;
    end else if (accept) begin
      opa_p0    <= a;
      opb_p0    <= b;
      borrow_p0 <= bin;
      k_p0      <= '0;
    end else if (state == BUSY) begin
      borrow_p0 <= s_bout;
      k_p0      <= last ? '0 : k_p0 + KW'(1);
    end
  end

  // Stage 1: result accumulation, held stable while DONE waits on the consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_p1 <= '0;
      skip_p1 <= '0;
      bout_p1 <= 1'b0;
      ovf_p1  <= 1'b0;
    end else if (accept) begin
      diff_p1 <= '0;
      skip_p1 <= '0;
    end else if (state == BUSY) begin
      diff_p1 <= diff_upd;
      if (s_skip) skip_p1 <= skip_p1 + SW'(1);
      if (last) begin
        bout_p1 <= s_bout;
        ovf_p1  <= (opa_p0[WIDTH-1] ^ opb_p0[WIDTH-1]) & (opa_p0[WIDTH-1] ^ s_diff[BLOCK-1]);
      end
    end
  end

  assign diff     = diff_p1;
  assign bout     = bout_p1;
  assign ovf      = ovf_p1;
  assign skip_cnt = skip_p1;

endmodule

// File: tb/tb_borrow_bypass_subtractor.sv
// Directed and randomized checks of borrow_bypass_subtractor at default parameters (8-bit, 4-bit slices).
module tb_borrow_bypass_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       bin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;
  logic [1:0] skip_cnt;

  int n_checks = 0;
  int n_errors = 0;

  borrow_bypass_subtractor #(.WIDTH(8), .BLOCK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf), .skip_cnt(skip_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands, wait for acceptance, then return the edges until out_valid.
  task automatic do_op(input logic [7:0] xa, input logic [7:0] xb, input logic xbin, output int lat);
    int n;
    a = xa; b = xb; bin = xbin; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (n >= 50) check("accept_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    if (lat >= 50) check("result_timeout", 0, 1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic [7:0] ed, input logic eb,
                            input logic eo, input logic [1:0] es);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_bout"}, bout, eb);
    check({tag, "_ovf"}, ovf, eo);
    check({tag, "_skip"}, skip_cnt, es);
  endtask

  initial begin
    int lat, n, results;
    logic [8:0] ref9;
    logic       ref_ovf;
    logic [1:0] ref_skip;
    logic [7:0] ra, rb, held;
    logic       rbin;

    // Reset state
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_diff", diff, 0);
    check("rst_skip", skip_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1);

    // Basic subtraction and latency
    do_op(8'h5A, 8'h3C, 1'b0, lat);
    check("t1_latency", lat, 2);
    expect_res("t1", 8'h1E, 1'b0, 1'b0, 2'd0);
    consume();
    check("t1_idle_out_valid", out_valid, 0);
    check("t1_idle_in_ready", in_ready, 1);
    check("t1_hold_diff", diff, 8'h1E);

    // Wrap-around and overflow
    do_op(8'h00, 8'h01, 1'b0, lat);
    expect_res("t2a", 8'hFF, 1'b1, 1'b0, 2'd1);
    consume();
    do_op(8'h80, 8'h01, 1'b0, lat);
    expect_res("t2b", 8'h7F, 1'b0, 1'b1, 2'd0);
    consume();

    // Full bypass
    do_op(8'hA5, 8'hA5, 1'b1, lat);
    expect_res("t3a", 8'hFF, 1'b1, 1'b0, 2'd2);
    consume();
    do_op(8'hA5, 8'hA5, 1'b0, lat);
    expect_res("t3b", 8'h00, 1'b0, 1'b0, 2'd2);
    consume();

    // Backpressure, then same-edge consume and accept
    do_op(8'h33, 8'h11, 1'b0, lat);
    a = 8'hFF; b = 8'h00; bin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_in_ready", in_ready, 0);
      check("t4_hold_diff", diff, 8'h22);
    end
    a = 8'h10; b = 8'h20; bin = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    check("t4_same_edge_busy", out_valid, 0);
    check("t4_same_edge_in_ready", in_ready, 0);
    a = 8'h77; b = 8'h66;
    tick();
    tick();
    check("t4_latency", out_valid, 1);
    expect_res("t4", 8'hF0, 1'b1, 1'b0, 2'd1);
    consume();

    // Reset mid-operation
    a = 8'h5A; b = 8'h3C; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("t5_out_valid", out_valid, 0);
    check("t5_diff", diff, 0);
    check("t5_skip", skip_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_in_ready", in_ready, 1);
    check("t5_no_result", out_valid, 0);
    do_op(8'hC3, 8'h3C, 1'b1, lat);
    check("t5_latency", lat, 2);
    expect_res("t5", 8'h86, 1'b0, 1'b0, 2'd0);
    consume();

    // Random regression with gaps on both handshakes
    results = 0;
    for (int op = 0; op < 10000; op++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      if (op % 16 == 0) rb = ra;
      ref9     = {1'b0, ra} - {1'b0, rb} - {8'b0, rbin};
      ref_ovf  = (ra[7] ^ rb[7]) & (ra[7] ^ ref9[7]);
      ref_skip = 2'(ra[3:0] == rb[3:0]) + 2'(ra[7:4] == rb[7:4]);
      n = $urandom_range(0, 1);
      for (int g = 0; g < n; g++) tick();
      do_op(ra, rb, rbin, lat);
      a = ~ra; b = ~rb;
      held = diff;
      n = $urandom_range(0, 2);
      for (int g = 0; g < n; g++) tick();
      if (out_valid) results++;
      check("rnd_diff", diff, ref9[7:0]);
      check("rnd_bout", bout, ref9[8]);
      check("rnd_ovf", ovf, ref_ovf);
      check("rnd_skip", skip_cnt, ref_skip);
      if (n > 0) check("rnd_stable", diff, held);
      consume();
      if (out_valid) check("rnd_dup", out_valid, 0);
    end
    check("rnd_result_count", results, 10000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
